// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: read-owner encoding and default sizes.
package ram_arb_pkg;

  localparam int DEF_AW            = 16;
  localparam int DEF_DW            = 32;
  localparam int DEF_VGA_BURST_MAX = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_IO   = 2'd3
  } owner_e;

endpackage

// File: rtl/ram_arbiter.sv
// Three-way arbiter (VGA, CPU, IO) in front of a single-port RAM with
// one-cycle read latency; read data returns on a shared bus tagged by rvalid.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW            = DEF_AW,
  parameter int DW            = DEF_DW,
  parameter int VGA_BURST_MAX = DEF_VGA_BURST_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  input  logic          io_req,
  input  logic [AW-1:0] io_addr,
  output logic          io_gnt,
  output logic [DW-1:0] rdata,
  output logic          vga_rvalid,
  output logic          cpu_rvalid,
  output logic          io_rvalid,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  localparam int BW = $clog2(VGA_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(VGA_BURST_MAX);

  // Handshake: a requester holds req (with addr/data) for as long as it wants
  // access; a grant is valid only in the cycle it is shown and is never
  // remembered. Read data for a granted read appears exactly one cycle later,
  // qualified by that requester's rvalid. CPU sees its grant as !cpu_stall.

  logic [BW-1:0] burst_cnt;
  logic          rr;         // 0 prefers CPU, 1 prefers IO
  owner_e        owner;

  logic other_req;
  logic vga_capped;
  logic vga_win;
  logic cpu_win;
  logic io_win;

  always_comb begin
    other_req  = cpu_req | io_req;
    vga_capped = (burst_cnt == BURST_MAX) && other_req;
    vga_win    = reset && vga_req && !vga_capped;
    cpu_win    = reset && !vga_win && cpu_req && (!io_req || !rr);
    io_win     = reset && !vga_win && io_req && (!cpu_req || rr);
  end

  assign vga_gnt   = vga_win;
  assign io_gnt    = io_win;
  assign cpu_stall = cpu_req & ~cpu_win;
  assign ram_wren  = cpu_win & cpu_we;

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    if (vga_win) begin
      ram_address = vga_addr;
    end else if (cpu_win) begin
      ram_address = cpu_addr;
      ram_data    = cpu_wdata;
    end else if (io_win) begin
      ram_address = io_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt <= '0;
      rr        <= 1'b0;
      owner     <= OWN_NONE;
    end else begin
      // The streak only grows while someone else is actually being held off.
      if (!vga_win) begin
        burst_cnt <= '0;
      end else if (other_req && burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
      if (cpu_win || io_win) begin
        rr <= ~rr;
      end
      if (vga_win) begin
        owner <= OWN_VGA;
      end else if (cpu_win && !cpu_we) begin
        owner <= OWN_CPU;
      end else if (io_win) begin
        owner <= OWN_IO;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // Gated by reset so a read granted just before reset never reports.
  assign vga_rvalid = reset && (owner == OWN_VGA);
  assign cpu_rvalid = reset && (owner == OWN_CPU);
  assign io_rvalid  = reset && (owner == OWN_IO);
  assign rdata      = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, rule-level reference arbiter, and a
// read-return scoreboard checked by an independent monitor.
module tb_ram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int VBM = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, io_req = 1'b0;
  logic [AW-1:0] vga_addr = '0, cpu_addr = '0, io_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          vga_gnt, cpu_stall, io_gnt, ram_wren;
  logic          vga_rvalid, cpu_rvalid, io_rvalid;
  logic [DW-1:0] rdata, ram_data;
  logic [DW-1:0] ram_q = '0;
  logic [AW-1:0] ram_address;

  ram_arbiter #(.AW(AW), .DW(DW), .VGA_BURST_MAX(VBM)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_addr(io_addr), .io_gnt(io_gnt),
    .rdata(rdata), .vga_rvalid(vga_rvalid), .cpu_rvalid(cpu_rvalid),
    .io_rvalid(io_rvalid), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // ---------------- clock / reset infrastructure ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- single-port RAM model (read-before-write) ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_rd;

  function automatic logic [DW-1:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    ram_rd = mem[ram_address];
    if (ram_wren) mem[ram_address] = ram_data;
    ram_q <= ram_rd;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            due;
    int            owner;   // 1 VGA, 2 CPU, 3 IO
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int m_streak    = 0;   // consecutive VGA wins while someone else waited
  bit m_prefer_io = 1'b0;

  // Drives one cycle of requests, checks the combinational response against
  // the rule-level model and queues the read return it implies.
  task automatic cycle(input logic rst, input logic vr, input logic [AW-1:0] va,
                       input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic ir,
                       input logic [AW-1:0] ia, output int dut_win);
    int            win;
    bit            others;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    exp_t          e;
    @(posedge clk);
    #1;
    reset = rst; vga_req = vr; vga_addr = va; cpu_req = cr; cpu_we = cw;
    cpu_addr = ca; cpu_wdata = cd; io_req = ir; io_addr = ia;
    if (!rst) exp_q.delete();
    others = cr || ir;
    if (!rst)                                      win = 0;
    else if (vr && !(m_streak == VBM && others))   win = 1;
    else if (cr && ir)                             win = m_prefer_io ? 3 : 2;
    else if (cr)                                   win = 2;
    else if (ir)                                   win = 3;
    else                                           win = 0;
    ea = '0; ed = '0;
    case (win)
      1: ea = va;
      2: begin ea = ca; ed = cd; end
      3: ea = ia;
      default: ;
    endcase
    #1;
    dut_win = vga_gnt ? 1 : io_gnt ? 3 : (cpu_req && !cpu_stall) ? 2 : 0;
    chk("winner", 64'(dut_win), 64'(win));
    chk("gnt_excl", 64'(vga_gnt & io_gnt), 64'd0);
    chk("cpu_stall", 64'(cpu_stall), 64'(cr && win != 2));
    chk("ram_wren", 64'(ram_wren), 64'(win == 2 && cw));
    chk("ram_address", 64'(ram_address), 64'(ea));
    chk("ram_data", 64'(ram_data), 64'(ed));
    if (win == 1 || win == 3 || (win == 2 && !cw)) begin
      e.due = edge_cnt + 1; e.owner = win; e.data = ref_mem[ea];
      exp_q.push_back(e);
    end
    if (win == 2 && cw) ref_mem[ca] = cd;
    if (!rst) begin
      m_streak = 0; m_prefer_io = 1'b0;
    end else begin
      if (win == 1) begin
        if (others && m_streak < VBM) m_streak++;
      end else begin
        m_streak = 0;
      end
      if (win == 2 || win == 3) m_prefer_io = !m_prefer_io;
    end
  endtask

  // ---------------- monitor: read returns ----------------
  logic [2:0]    mon_got, mon_want;
  logic [DW-1:0] mon_data;
  always @(negedge clk) begin
    mon_got  = {vga_rvalid, cpu_rvalid, io_rvalid};
    mon_want = 3'b000;
    mon_data = '0;
    if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      mon_want = (exp_q[0].owner == 1) ? 3'b100 : (exp_q[0].owner == 2) ? 3'b010 : 3'b001;
      mon_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("rvalid", 64'(mon_got), 64'(mon_want));
    if (mon_want != 3'b000) chk("rdata", 64'(rdata), 64'(mon_data));
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Reset with requests present: no grants, stall mirrors cpu_req.
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 16'h1, i[0], 1'b1, 16'h2, 32'h1, 1'b1, 16'h3, w);

    // All three requesting: 8 VGA, CPU, 8 VGA, IO, repeating.
    for (int i = 0; i < 36; i++) begin
      int pos;
      cycle(1'b1, 1'b1, 16'($urandom_range(0, 63)), 1'b1, 1'b0,
            16'($urandom_range(0, 63)), $urandom, 1'b1, 16'($urandom_range(0, 63)), w);
      pos = i % 18;
      chk("burst_pattern", 64'(w), 64'((pos == 8) ? 2 : (pos == 17) ? 3 : 1));
    end

    // CPU and IO only: strict alternation starting with CPU.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'(i), 32'h0, 1'b1, 16'(i + 100), w);
      chk("cpu_io_alternate", 64'(w), 64'((i % 2) ? 3 : 2));
    end

    // CPU store then IO read of the same word.
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b0, 16'h0, w);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 16'h0010, w);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);
    chk("store_readback", 64'(ref_mem[16'h0010]), 64'h0000_0000_DEAD_BEEF);

    // Back-to-back VGA, CPU, IO reads.
    cycle(1'b1, 1'b1, 16'h1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h2, 32'h0, 1'b0, 16'h0, w);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 16'h3, w);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);

    // VGA read then reset in the next cycle: the read must vanish.
    cycle(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h5, 32'h0, 1'b1, 16'h6, w);
    chk("post_reset_cpu_first", 64'(w), 64'd2);

    // Randomized traffic with occasional resets and address collisions.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7),
            16'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1) == 1, 16'($urandom_range(0, 15)), w);
    end

    // Drain and confirm every expected return was seen.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0, w);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
